alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, multi-cycle successor to the processor's combinational ALU. Accepts one operation at a time over a valid/ready handshake. Single-cycle ops complete in one cycle; shifts and population count iterate one bit per cycle. Results and a registered flag set (carry, zero, parity, compare) are held until the consumer accepts them. It sits between decode and writeback and feeds the branch unit from its registered compare code.

## Interface
- `W`, default 8: data width; must be ≥ 2.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block idle, can accept
- `op`  in  4  opcode (`op_e`)
- `a`  in  W  operand A; also the shift amount for SHL/SHR
- `b`  in  W  operand B; the value being shifted for SHL/SHR
- `carry_in`  in  1  carry in for ADD/SUB
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `result`  out  W  operation result
- `carry`  out  1  carry flag
- `zero`  out  1  result == 0
- `parity`  out  1  XOR-reduce of result
- `cmp`  out  2  compare code: 00 eq, 01 a>b, 10 a<b (unsigned)
- `err`  out  1  last accepted opcode illegal

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture the op and operands.
  - Single-cycle ops go to DONE with the result computed.
  - SHL/SHR/POPCNT load the iterator and go to ITER.
  - SHL/SHR with amount 0 go straight to DONE.
- Opcodes:
  - 0 ADD: {carry,result} = a + b + carry_in.
  - 1 SUB: {carry,result} = a + ~b + carry_in. `carry_in`=1 gives a plain subtract; carry=1 means no borrow.
  - 2 AND, 3 OR, 4 XOR, 7 NOT (~a), 10 MOV (result = a).
  - 5 SHL / 6 SHR: result = b shifted by n.
    - n = a (unsigned), clipped to W.
    - One bit per ITER cycle.
    - carry = last bit shifted out; 0 if n=0.
  - 8 POPCNT: count of ones in a. Takes exactly W ITER cycles, scanning bit 0 upward. Width rule: result zero-extended.
  - 9 CMP: result = a − b mod 2^W, carry as SUB with an implicit `carry_in`=1; `cmp` is updated.
  - 11–15: result 0, err=1, all other flags unchanged.
- Flag update rules:
  - `zero` and `parity` are updated for every legal op.
  - `carry` is updated by ADD/SUB/SHL/SHR/CMP only.
  - `cmp` is updated by CMP only.
  - `err` is updated on every accept.
- DONE: `out_valid`=1 and the outputs are stable. On `out_ready`, go to IDLE.
- `in_ready` is 0 in ITER and DONE. There is no overlap of operations.

## Timing
- Reset:
  - State IDLE.
  - result=0, carry=0, zero=1, parity=0, cmp=00, err=0.
  - `out_valid`=0, `in_ready`=1.
- Reset during ITER or DONE aborts the operation; the same reset values apply on the next cycle.
- Define k as the accept edge. `out_valid` rises at k+1 for single-cycle ops, k+n+1 for shifts, and k+W+1 for POPCNT.
- DONE → IDLE on the edge where `out_ready`=1. A new op can be accepted on the following edge, giving a throughput of one op per 2 cycles at best.
- `out_ready` held low: result and flags hold indefinitely.
- Flags and result change only on the edge entering DONE.
- `in_valid` while not IDLE: ignored; the operands are not sampled.

## Structure
- Package `alu_mc_pkg`:
  - `op_e` (4-bit opcode enum).
  - `cmp_e` (EQ=00, GT=01, LT=10).
  - `state_e`.
- Sub-module `alu_mc_core`: purely combinational single-cycle op unit (ADD..MOV, CMP) with a carry output.
- Top-level contents: the FSM, the shift/popcount iterator (bit counter of width $clog2(W)+1), and the flag registers.

## Test plan
- ADD: a=0xF0, b=0x20, cin=0 → result 0x10, carry=1, zero=0, parity=1; `out_valid` at k+1.
- SUB: a=0x05, b=0x05, cin=1 → result 0x00, carry=1, zero=1, parity=0, cmp unchanged (00 from reset).
- Shifts:
  - SHL a=1, b=0x81 → 0x02, carry=1, `out_valid` at k+2.
  - SHL a=20, b=0x81 → clipped to 8 → result 0x00, carry=1, `out_valid` at k+9.
- POPCNT a=0xB7 → result 0x06, `out_valid` at k+9, carry unchanged.
- CMP a=3, b=9 → result 0xFA, carry=0, cmp=10.
  - Then CMP a=9, b=3 → cmp=01.
  - Then ADD → cmp stays 01.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles after MOV a=0x5A → result 0x5A stable, `in_ready`=0, `in_valid` ignored.
  - Assert reset mid-ITER of POPCNT → next cycle shows the full reset values.
  - Opcode 13 → err=1, result 0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, compare codes and FSM states.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SHL    = 4'd5,
        OP_SHR    = 4'd6,
        OP_NOT    = 4'd7,
        OP_POPCNT = 4'd8,
        OP_CMP    = 4'd9,
        OP_MOV    = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_e;

    // Unsigned three-way compare feeding the branch unit's compare code.
    function automatic cmp_e cmp_code(input logic [63:0] a, input logic [63:0] b);
        if (a == b)
            return CMP_EQ;
        else if (a > b)
            return CMP_GT;
        else
            return CMP_LT;
    endfunction

endpackage

// File: rtl/alu_mc_core.sv
// Combinational single-cycle op unit (ADD..MOV, CMP); shifts and popcount live in the top.
module alu_mc_core
    import alu_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  op_e            op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           carry_in,
    output logic [W-1:0]   result,
    output logic           carry_out
);

    logic [W:0] sum_add;
    logic [W:0] sum_sub;
    logic [W:0] sum_cmp;

    // Subtract is a + ~b + cin, so carry=1 means no borrow; CMP forces cin=1.
    assign sum_add = {1'b0, a} + {1'b0, b}  + {{W{1'b0}}, carry_in};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, carry_in};
    assign sum_cmp = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        case (op)
            OP_ADD: {carry_out, result} = sum_add;
            OP_SUB: {carry_out, result} = sum_sub;
            OP_CMP: {carry_out, result} = sum_cmp;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_MOV: result = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready front end, bit-serial shift/popcount iterator and
// registered result/flags held until the consumer takes them.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         parity,
    output logic [1:0]   cmp,
    output logic         err
);

    localparam int CW = $clog2(W) + 1;

    state_e state_q, state_d;
    op_e    op_in;

    logic [W-1:0]  core_result;
    logic          core_carry;
    logic [CW-1:0] n_clip;

    // Iterator working registers; visible flags only move when DONE is entered.
    op_e           it_op;
    logic [W-1:0]  it_data, it_data_nx;
    logic [CW-1:0] it_acc, it_acc_nx;
    logic          it_carry, it_carry_nx;
    logic [CW-1:0] cnt;

    logic          start_it;
    logic          fin_load;
    logic [W-1:0]  fin_result;
    logic          fin_carry;
    logic          fin_upd_carry;
    logic          fin_upd_zp;
    logic          fin_upd_cmp;
    cmp_e          fin_cmp;
    logic          fin_err;

    logic [W-1:0]  result_q;
    logic          carry_q, zero_q, parity_q, err_q;
    cmp_e          cmp_q;

    assign op_in = op_e'(op);

    // Shift amount is a, clipped to W so an oversized shift still ends in W cycles.
    assign n_clip = (a >= W'(W)) ? CW'(W) : CW'(a);

    alu_mc_core #(.W(W)) u_core (
        .op        (op_in),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .result    (core_result),
        .carry_out (core_carry)
    );

    always_comb begin
        it_data_nx  = it_data;
        it_acc_nx   = it_acc;
        it_carry_nx = it_carry;
        case (it_op)
            OP_SHL: begin
                it_carry_nx = it_data[W-1];
                it_data_nx  = it_data << 1;
            end
            OP_SHR: begin
                it_carry_nx = it_data[0];
                it_data_nx  = it_data >> 1;
            end
            default: begin
                it_acc_nx  = it_acc + CW'(it_data[0]);
                it_data_nx = it_data >> 1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        start_it      = 1'b0;
        fin_load      = 1'b0;
        fin_result    = '0;
        fin_carry     = 1'b0;
        fin_upd_carry = 1'b0;
        fin_upd_zp    = 1'b0;
        fin_upd_cmp   = 1'b0;
        fin_cmp       = CMP_EQ;
        fin_err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op_in)
                        OP_SHL, OP_SHR: begin
                            if (n_clip == '0) begin
                                state_d       = ST_DONE;
                                fin_load      = 1'b1;
                                fin_result    = b;
                                fin_upd_carry = 1'b1;
                                fin_upd_zp    = 1'b1;
                            end else begin
                                state_d  = ST_ITER;
                                start_it = 1'b1;
                            end
                        end
                        OP_POPCNT: begin
                            state_d  = ST_ITER;
                            start_it = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_CMP: begin
                            state_d       = ST_DONE;
                            fin_load      = 1'b1;
                            fin_result    = core_result;
                            fin_carry     = core_carry;
                            fin_upd_carry = 1'b1;
                            fin_upd_zp    = 1'b1;
                            fin_upd_cmp   = (op_in == OP_CMP);
                            fin_cmp       = cmp_code(64'(a), 64'(b));
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
                            state_d    = ST_DONE;
                            fin_load   = 1'b1;
                            fin_result = core_result;
                            fin_upd_zp = 1'b1;
                        end
                        default: begin
                            state_d  = ST_DONE;
                            fin_load = 1'b1;
                            fin_err  = 1'b1;
                        end
                    endcase
                end
            end
            ST_ITER: begin
                if (cnt == CW'(1)) begin
                    state_d       = ST_DONE;
                    fin_load      = 1'b1;
                    fin_upd_zp    = 1'b1;
                    fin_result    = (it_op == OP_POPCNT) ? W'(it_acc_nx) : it_data_nx;
                    fin_carry     = it_carry_nx;
                    fin_upd_carry = (it_op != OP_POPCNT);
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start_it)
            cnt <= (op_in == OP_POPCNT) ? CW'(W) : n_clip;
        else if (state_q == ST_ITER)
            cnt <= cnt - CW'(1);
    end

    // Popcount scans a from bit 0 upward through the same shift register shifts use.
    always_ff @(posedge clk) begin
        if (start_it) begin
            it_op    <= op_in;
            it_data  <= (op_in == OP_POPCNT) ? a : b;
            it_acc   <= '0;
            it_carry <= 1'b0;
        end else if (state_q == ST_ITER) begin
            it_data  <= it_data_nx;
            it_acc   <= it_acc_nx;
            it_carry <= it_carry_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            cmp_q    <= CMP_EQ;
            err_q    <= 1'b0;
        end else if (fin_load) begin
            result_q <= fin_result;
            err_q    <= fin_err;
            if (fin_upd_zp) begin
                zero_q   <= ~|fin_result;
                parity_q <= ^fin_result;
            end
            if (fin_upd_carry)
                carry_q <= fin_carry;
            if (fin_upd_cmp)
                cmp_q <= fin_cmp;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign cmp       = cmp_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: latency, result and flag behaviour per feature.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, zero, parity, err;
    logic [1:0]   cmp;
    logic [12:0]  obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [12:0] exp;   // {result, carry, zero, parity, cmp}
        int          lat;
    } vec_t;

    alu_mc #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .parity    (parity),
        .cmp       (cmp),
        .err       (err)
    );

    assign obs = {result, carry, zero, parity, cmp};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    // Offers one op, then counts cycles from the accept edge until out_valid (bounded).
    task automatic do_op(input vec_t v, output int lat);
        op = v.op; a = v.a; b = v.b; carry_in = v.ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 2'b00}) begin
            errors++; $display("FAIL reset_flags got %h exp %h", obs, {8'h00, 1'b0, 1'b1, 1'b0, 2'b00});
        end
        checks++;
        if ({in_ready, out_valid, err} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl got %b exp 100", {in_ready, out_valid, err});
        end
    endtask

    task automatic test_add_sub;
        vec_t v[2];
        int lat;
        v[0] = '{4'd0, 8'hF0, 8'h20, 1'b0, {8'h10, 1'b1, 1'b0, 1'b1, 2'b00}, 1};
        v[1] = '{4'd1, 8'h05, 8'h05, 1'b1, {8'h00, 1'b1, 1'b1, 1'b0, 2'b00}, 1};
        foreach (v[i]) begin
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL add_sub[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++;
            if (obs !== v[i].exp) begin errors++; $display("FAIL add_sub[%0d] flags got %h exp %h", i, obs, v[i].exp); end
            finish_op;
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL add_sub[%0d] release got %b exp 10", i, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_shift;
        vec_t v[4];
        int lat;
        v[0] = '{4'd5, 8'd1,  8'h81, 1'b0, {8'h02, 1'b1, 1'b0, 1'b1, 2'b00}, 2};
        v[1] = '{4'd5, 8'd20, 8'h81, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 2'b00}, 9};
        v[2] = '{4'd6, 8'd0,  8'h3C, 1'b0, {8'h3C, 1'b0, 1'b0, 1'b0, 2'b00}, 1};
        v[3] = '{4'd6, 8'd2,  8'h3E, 1'b0, {8'h0F, 1'b1, 1'b0, 1'b0, 2'b00}, 3};
        foreach (v[i]) begin
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL shift[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++;
            if (obs !== v[i].exp) begin errors++; $display("FAIL shift[%0d] flags got %h exp %h", i, obs, v[i].exp); end
            finish_op;
        end
    endtask

    task automatic test_popcnt;
        vec_t v[2];
        int lat;
        // carry=1 left over from the previous shift must survive popcount
        v[0] = '{4'd8, 8'hB7, 8'h00, 1'b0, {8'h06, 1'b1, 1'b0, 1'b0, 2'b00}, 9};
        v[1] = '{4'd8, 8'h00, 8'hFF, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 2'b00}, 9};
        foreach (v[i]) begin
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL popcnt[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++;
            if (obs !== v[i].exp) begin errors++; $display("FAIL popcnt[%0d] flags got %h exp %h", i, obs, v[i].exp); end
            finish_op;
        end
    endtask

    task automatic test_cmp;
        vec_t v[4];
        int lat;
        v[0] = '{4'd9, 8'd3,   8'd9,   1'b0, {8'hFA, 1'b0, 1'b0, 1'b0, 2'b10}, 1};
        v[1] = '{4'd9, 8'd9,   8'd3,   1'b1, {8'h06, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        v[2] = '{4'd0, 8'h01,  8'h01,  1'b0, {8'h02, 1'b0, 1'b0, 1'b1, 2'b01}, 1};
        v[3] = '{4'd0, 8'hFF,  8'h01,  1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 2'b01}, 1};
        foreach (v[i]) begin
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL cmp[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++;
            if (obs !== v[i].exp) begin errors++; $display("FAIL cmp[%0d] flags got %h exp %h", i, obs, v[i].exp); end
            finish_op;
        end
    endtask

    task automatic test_logic;
        vec_t v[4];
        int lat;
        v[0] = '{4'd2, 8'hF0, 8'h3C, 1'b1, {8'h30, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        v[1] = '{4'd3, 8'hF0, 8'h3C, 1'b0, {8'hFC, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        v[2] = '{4'd4, 8'hF0, 8'h3C, 1'b0, {8'hCC, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        v[3] = '{4'd7, 8'hF0, 8'h3C, 1'b0, {8'h0F, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        foreach (v[i]) begin
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL logic[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++;
            if ({obs, err} !== {v[i].exp, 1'b0}) begin errors++; $display("FAIL logic[%0d] flags got %h exp %h", i, {obs, err}, {v[i].exp, 1'b0}); end
            finish_op;
        end
    endtask

    task automatic test_backpressure;
        vec_t v;
        int lat;
        v = '{4'd10, 8'h5A, 8'h00, 1'b0, {8'h5A, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        do_op(v, lat);
        checks++;
        if (lat !== 1 || obs !== v.exp) begin errors++; $display("FAIL mov got lat %0d flags %h exp lat 1 flags %h", lat, obs, v.exp); end
        for (int c = 0; c < 5; c++) begin
            op = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({obs, in_ready, out_valid} !== {v.exp, 1'b0, 1'b1}) begin
                errors++; $display("FAIL hold[%0d] got %h exp %h", c, {obs, in_ready, out_valid}, {v.exp, 1'b0, 1'b1});
            end
        end
        in_valid = 1'b0;
        finish_op;
        @(posedge clk); #1;
        checks++;
        if ({obs, in_ready, out_valid} !== {v.exp, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hold_release got %h exp %h", {obs, in_ready, out_valid}, {v.exp, 1'b1, 1'b0});
        end
    endtask

    task automatic test_illegal;
        vec_t v;
        int lat;
        // result forced to 0 but zero/parity/carry/cmp keep their MOV-era values
        v = '{4'd13, 8'hFF, 8'hFF, 1'b1, {8'h00, 1'b1, 1'b0, 1'b0, 2'b01}, 1};
        do_op(v, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL illegal latency got %0d exp 1", lat); end
        checks++;
        if ({obs, err} !== {v.exp, 1'b1}) begin errors++; $display("FAIL illegal flags got %h exp %h", {obs, err}, {v.exp, 1'b1}); end
        finish_op;
    endtask

    task automatic test_reset_mid_iter;
        op = 4'd8; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL iter_busy got %b exp 00", {in_ready, out_valid}); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({obs, err, in_ready, out_valid} !== {8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mid_iter_reset got %h exp %h", {obs, err, in_ready, out_valid},
                               {8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL post_reset_idle got %h exp %h", {in_ready, out_valid, result}, {1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[2];
        int lat;
        v[0] = '{4'd0, 8'h07, 8'h08, 1'b1, {8'h10, 1'b0, 1'b0, 1'b1, 2'b00}, 1};
        v[1] = '{4'd1, 8'h10, 8'h01, 1'b1, {8'h0F, 1'b1, 1'b0, 1'b0, 2'b00}, 1};
        foreach (v[i]) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] in_ready got %b exp 1", i, in_ready); end
            do_op(v[i], lat);
            checks++;
            if (lat !== v[i].lat || obs !== v[i].exp) begin
                errors++; $display("FAIL b2b[%0d] got lat %0d flags %h exp lat %0d flags %h", i, lat, obs, v[i].lat, v[i].exp);
            end
            finish_op;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_add_sub;
        test_shift;
        test_popcnt;
        test_cmp;
        test_logic;
        test_backpressure;
        test_illegal;
        test_reset_mid_iter;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
